// File: rtl/uart_deserialized.sv
// uart_deserialized
// Receives 8N1 bytes from the host RX line and assembles them, first byte in
// the least significant lane, into a DATA_WIDTH_BYTES-wide frame that ends
// with a TERMINATOR byte.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   rx_in        asynchronous UART RX line, idles high
//   data_out     last good frame payload, byte k in bits [8k+7:8k]
//   data_valid   one-cycle pulse when data_out is updated
//   frame_error  one-cycle pulse when a frame or byte is rejected
//   byte_valid   one-cycle pulse for every correctly framed byte
//   rx_byte      last correctly framed byte, updated with byte_valid
//   busy         high while the bit FSM is outside IDLE
//
// State | meaning
// IDLE    | waiting for a low level on the synchronized line
// START   | half-bit wait, then confirm the start bit (high = glitch)
// DATA    | sample 8 data bits, LSB first, one per bit period
// STOP    | sample stop bit; byte accepted or framing error
// CLEANUP | one settle cycle before returning to IDLE
module uart_deserialized #(
  parameter int unsigned     CLKS_PER_BIT     = 2604,
  parameter int unsigned     DATA_WIDTH_BYTES = 4,
  parameter logic [7:0]      TERMINATOR       = 8'h0A
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic [8*DATA_WIDTH_BYTES-1:0] data_out,
  output logic                          data_valid,
  output logic                          frame_error,
  output logic                          byte_valid,
  output logic [7:0]                    rx_byte,
  output logic                          busy
);

  localparam int unsigned CNTW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BCW  = $clog2(DATA_WIDTH_BYTES + 1);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0]  FULL_CNT  = BCW'(DATA_WIDTH_BYTES);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, CLEANUP
  } state_t;

  state_t                        state_q;
  logic                          rx_meta_q, rx_s_q;
  logic [CNTW-1:0]               clk_cnt_q;
  logic [2:0]                    bit_idx_q;
  logic [7:0]                    shift_q;
  logic [BCW-1:0]                byte_cnt_q;
  logic                          discard_q;
  logic [8*DATA_WIDTH_BYTES-1:0] stage_q;
  logic [8*DATA_WIDTH_BYTES-1:0] data_out_q;
  logic                          data_valid_q, frame_error_q, byte_valid_q;
  logic [7:0]                    rx_byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      // Preset high so releasing reset never looks like a start bit.
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      discard_q     <= 1'b0;
      stage_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      byte_valid_q  <= 1'b0;
      rx_byte_q     <= '0;
    end else begin
      rx_meta_q     <= rx_in;
      rx_s_q        <= rx_meta_q;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      byte_valid_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end

        START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end

        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end

        STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= CLEANUP;
            if (rx_s_q) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
              // Frame assembly runs only on a good byte.
              if (discard_q) begin
                if (shift_q == TERMINATOR) begin
                  discard_q  <= 1'b0;
                  byte_cnt_q <= '0;
                end
              end else if (shift_q == TERMINATOR) begin
                if (byte_cnt_q == FULL_CNT) begin
                  data_out_q   <= stage_q;
                  data_valid_q <= 1'b1;
                end else begin
                  frame_error_q <= 1'b1;
                end
                byte_cnt_q <= '0;
              end else if (byte_cnt_q == FULL_CNT) begin
                // Overlong: drop everything up to the next terminator.
                frame_error_q <= 1'b1;
                discard_q     <= 1'b1;
                byte_cnt_q    <= '0;
              end else begin
                for (int k = 0; k < int'(DATA_WIDTH_BYTES); k++) begin
                  if (byte_cnt_q == BCW'(k)) stage_q[8*k +: 8] <= shift_q;
                end
                byte_cnt_q <= byte_cnt_q + BCW'(1);
              end
            end else begin
              frame_error_q <= 1'b1;
              byte_cnt_q    <= '0;
              discard_q     <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNTW'(1);
          end
        end

        CLEANUP: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign byte_valid  = byte_valid_q;
  assign rx_byte     = rx_byte_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_deserialized.sv
module tb_uart_deserialized;

  localparam int CPB  = 16;
  localparam int DWB  = 4;
  localparam logic [7:0] TERM = 8'h0A;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_in;
  logic [8*DWB-1:0]  data_out;
  logic              data_valid, frame_error, byte_valid, busy;
  logic [7:0]        rx_byte;

  uart_deserialized #(
    .CLKS_PER_BIT(CPB), .DATA_WIDTH_BYTES(DWB), .TERMINATOR(TERM)
  ) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in), .data_out(data_out),
    .data_valid(data_valid), .frame_error(frame_error),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             bv;
    logic             dv;
    logic             fe;
    logic [7:0]       rxb;
    logic [8*DWB-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a list of payload bytes plus a discard flag.
  logic [7:0]       m_payload[$];
  bit               m_discard = 0;
  logic [8*DWB-1:0] m_data    = '0;
  logic [7:0]       m_rxb     = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_payload.delete();
    m_discard = 0;
    m_data    = '0;
    m_rxb     = '0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    exp_t r;
    r.bv = stop_ok; r.dv = 0; r.fe = 0;
    if (!stop_ok) begin
      r.fe = 1;
      m_payload.delete();
      m_discard = 1;
    end else begin
      m_rxb = b;
      if (m_discard) begin
        if (b == TERM) begin
          m_discard = 0;
          m_payload.delete();
        end
      end else if (b == TERM) begin
        if (m_payload.size() == DWB) begin
          for (int k = 0; k < DWB; k++) m_data[8*k +: 8] = m_payload[k];
          r.dv = 1;
        end else begin
          r.fe = 1;
        end
        m_payload.delete();
      end else if (m_payload.size() < DWB) begin
        m_payload.push_back(b);
      end else begin
        r.fe = 1;
        m_discard = 1;
        m_payload.delete();
      end
    end
    r.rxb  = m_rxb;
    r.data = m_data;
    exp_q.push_back(r);
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle_bits);
    int idle;
    idle = idle_bits;
    if (!stop_ok && idle < 1) idle = 1;
    model_byte(b, stop_ok);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok ? 1'b1 : 1'b0, CPB);
    if (idle > 0) drive(1'b1, idle * CPB);
    else          rx_in = 1'b1;
  endtask

  task automatic send_frame(input logic [8*DWB-1:0] payload);
    for (int k = 0; k < DWB; k++) send_byte(payload[8*k +: 8], 1'b1, 1);
    send_byte(TERM, 1'b1, 2);
  endtask

  // Monitor: every pulse cycle consumes one expected record.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (!reset && (byte_valid || data_valid || frame_error)) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: bv=%0b dv=%0b fe=%0b with no expectation at %0t",
                   byte_valid, data_valid, frame_error, $time);
        end else begin
          r = exp_q.pop_front();
          chk("byte_valid",  64'(byte_valid),  64'(r.bv));
          chk("data_valid",  64'(data_valid),  64'(r.dv));
          chk("frame_error", 64'(frame_error), 64'(r.fe));
          chk("rx_byte",     64'(rx_byte),     64'(r.rxb));
          chk("data_out",    64'(data_out),    64'(r.data));
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int len;
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_data_out",    64'(data_out),    64'd0);
    chk("rst_data_valid",  64'(data_valid),  64'd0);
    chk("rst_frame_error", 64'(frame_error), 64'd0);
    chk("rst_byte_valid",  64'(byte_valid),  64'd0);
    chk("rst_rx_byte",     64'(rx_byte),     64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    drive(1'b1, 2 * CPB);

    // Good frame.
    send_frame(32'h44332211);
    // Short frame, then good frame.
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(TERM,  1'b1, 1);
    send_frame(32'hDDCCBBAA);
    // Overlong frame, discard, then good frame.
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1, 0);
    send_byte(TERM, 1'b1, 1);
    send_frame(32'hD4C3B2A1);
    // Bad stop bit poisons the following frame; the one after is accepted.
    send_byte(8'h55, 1'b0, 1);
    send_frame(32'h78563412);
    send_frame(32'hF0DEBC9A);
    // Idle glitch, then back-to-back terminators.
    drive(1'b0, 5);
    drive(1'b1, 2 * CPB);
    chk("glitch_busy", 64'(busy), 64'd0);
    send_byte(TERM, 1'b1, 0);
    send_byte(TERM, 1'b1, 1);

    // Reset in the middle of bit 3 of byte 2.
    send_byte(8'h5A, 1'b1, 0);
    send_byte(8'hC3, 1'b1, 0);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB / 2);
    chk("mid_byte_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx_in = 1'b1;
    model_reset();
    chk("rst2_data_out",    64'(data_out),    64'd0);
    chk("rst2_data_valid",  64'(data_valid),  64'd0);
    chk("rst2_frame_error", 64'(frame_error), 64'd0);
    chk("rst2_byte_valid",  64'(byte_valid),  64'd0);
    chk("rst2_rx_byte",     64'(rx_byte),     64'd0);
    chk("rst2_busy",        64'(busy),        64'd0);
    drive(1'b1, 2 * CPB);
    send_frame(32'h0BADCAFE);

    // Randomized frames: random lengths, occasional bad stop bits.
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        send_byte(b, ($urandom_range(0, 11) != 0), $urandom_range(0, 2));
      end
      send_byte(TERM, 1'b1, $urandom_range(0, 2));
    end

    drive(1'b1, 4 * CPB);
    chk("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
